// File: rtl/branch_predictor_unit.sv
// Branch predictor: direct-mapped BTB plus a table of saturating direction
// counters (PHT). Lookup is purely combinational from the registered
// tables. Updates from the execute stage are written on the clock edge.
//
// Optional feature macro: GSHARE_EN
//   undefined : bimodal PHT indexing, ghr_o tied to zero, no history register
//   defined   : gshare PHT indexing (pc index XOR global history)
module branch_predictor_unit #(
    parameter int Width   = 32,
    parameter int Entries = 16,
    parameter int TagW    = 4,
    parameter int CntBits = 2,
    parameter int GhrBits = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [Width-1:0]   pc_i,
    output logic               hit_o,
    output logic               pred_taken_o,
    output logic [Width-1:0]   pred_target_o,
    output logic [GhrBits-1:0] ghr_o,
    input  logic               upd_valid_i,
    input  logic [Width-1:0]   upd_pc_i,
    input  logic               upd_taken_i,
    input  logic [Width-1:0]   upd_target_i,
    input  logic               upd_pred_i,
    input  logic [GhrBits-1:0] upd_ghr_i,
    output logic [31:0]        mispred_cnt_o
);

    localparam int IdxW = $clog2(Entries);

    // Weakly not-taken: just below the taken threshold.
    localparam logic [CntBits-1:0] CntInit = CntBits'((1 << (CntBits - 1)) - 1);
    localparam logic [CntBits-1:0] CntMax  = {CntBits{1'b1}};

    // Saturating up/down step of a direction counter.
    function automatic logic [CntBits-1:0] sat_step(input logic [CntBits-1:0] cnt,
                                                    input logic               up);
        logic [CntBits-1:0] res;
        res = cnt;
        if (up) begin
            if (cnt != CntMax) res = cnt + CntBits'(1);
        end else begin
            if (cnt != '0) res = cnt - CntBits'(1);
        end
        return res;
    endfunction

    // Saturating increment of the 32-bit misprediction counter.
    function automatic logic [31:0] sat_inc32(input logic [31:0] cnt);
        logic [31:0] res;
        res = cnt;
        if (cnt != 32'hFFFF_FFFF) res = cnt + 32'd1;
        return res;
    endfunction

    // Table storage
    logic [Entries-1:0] r_btb_vld;
    logic [TagW-1:0]    r_btb_tag [Entries];
    logic [Width-1:0]   r_btb_tgt [Entries];
    logic [CntBits-1:0] r_pht     [Entries];
    logic [31:0]        r_mispred;

    // Address fields
    logic [IdxW-1:0] w_lk_idx;
    logic [TagW-1:0] w_lk_tag;
    logic [IdxW-1:0] w_up_idx;
    logic [TagW-1:0] w_up_tag;
    logic [IdxW-1:0] w_lk_pht_idx;
    logic [IdxW-1:0] w_up_pht_idx;
    logic            w_hit;
    logic            w_alloc;
    logic            w_mispred;
    logic            w_unused_upc;

    assign w_lk_idx = pc_i[IdxW+1:2];
    assign w_lk_tag = pc_i[IdxW+TagW+1:IdxW+2];
    assign w_up_idx = upd_pc_i[IdxW+1:2];
    assign w_up_tag = upd_pc_i[IdxW+TagW+1:IdxW+2];

    // Byte-offset bits and address bits above the tag do not take part.
    assign w_unused_upc = ^upd_pc_i;

    assign w_alloc   = upd_valid_i & upd_taken_i;
    assign w_mispred = upd_valid_i & (upd_taken_i != upd_pred_i);

`ifdef GSHARE_EN
    logic [GhrBits-1:0] r_ghr;

    // Global history: shift in each resolved direction, oldest bit falls off.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ghr <= '0;
        end else if (upd_valid_i) begin
            r_ghr <= (r_ghr << 1) | GhrBits'(upd_taken_i);
        end
    end

    // Lookup hashes with the live history; update hashes with the snapshot
    // that travelled with the instruction so both hit the same counter.
    assign w_lk_pht_idx = w_lk_idx ^ IdxW'(r_ghr);
    assign w_up_pht_idx = w_up_idx ^ IdxW'(upd_ghr_i);
    assign ghr_o        = r_ghr;
`else
    logic w_unused_ghr;

    assign w_unused_ghr = ^upd_ghr_i;
    assign w_lk_pht_idx = w_lk_idx;
    assign w_up_pht_idx = w_up_idx;
    assign ghr_o        = '0;
`endif

    // PHT counters: reset to weakly not-taken, saturating step on each update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Entries; i++) begin
                r_pht[i] <= CntInit;
            end
        end else if (upd_valid_i) begin
            r_pht[w_up_pht_idx] <= sat_step(r_pht[w_up_pht_idx], upd_taken_i);
        end
    end

    // BTB valid bits: cleared by reset, set when a taken branch allocates.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_btb_vld <= '0;
        end else if (w_alloc) begin
            r_btb_vld[w_up_idx] <= 1'b1;
        end
    end

    // BTB tag/target payload: no reset, only meaningful behind a valid bit.
    always_ff @(posedge clk_i) begin
        if (rst_ni && w_alloc) begin
            r_btb_tag[w_up_idx] <= w_up_tag;
            r_btb_tgt[w_up_idx] <= upd_target_i;
        end
    end

    // Misprediction counter, saturating at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mispred <= '0;
        end else if (w_mispred) begin
            r_mispred <= sat_inc32(r_mispred);
        end
    end

    // Combinational lookup from the registered tables.
    assign w_hit         = r_btb_vld[w_lk_idx] && (r_btb_tag[w_lk_idx] == w_lk_tag);
    assign hit_o         = w_hit;
    assign pred_taken_o  = w_hit & r_pht[w_lk_pht_idx][CntBits-1];
    assign pred_target_o = w_hit ? r_btb_tgt[w_lk_idx] : (pc_i + Width'(4));
    assign mispred_cnt_o = r_mispred;

endmodule

// File: doc/branch_predictor_unit.md
BRANCH_PREDICTOR_UNIT -- requirements
Module: branch_predictor_unit

Interface
REQ-001 SHALL have parameter Width, default 32: instruction address and target width.
REQ-002 SHALL have parameter Entries, default 16, power of two ≥ 2: BTB and PHT depth; IdxW = log2(Entries).
REQ-003 SHALL have parameter TagW, default 4: BTB tag width.
REQ-004 SHALL have parameter CntBits, default 2, range 1..4: saturating counter width.
REQ-005 SHALL have parameter GhrBits, default 4, ≤ IdxW: global history length.
REQ-006 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-008 SHALL have port pc_i  input  Width  IF-stage fetch address.
REQ-009 SHALL have port hit_o  output  1  valid BTB entry with matching tag.
REQ-010 SHALL have port pred_taken_o  output  1  predict taken.
REQ-011 SHALL have port pred_target_o  output  Width  predicted target.
REQ-012 SHALL have port ghr_o  output  GhrBits  history snapshot, carried down the pipe with the instruction.
REQ-013 SHALL have port upd_valid_i  input  1  resolved conditional branch or jump in EX.
REQ-014 SHALL have port upd_pc_i  input  Width  resolved instruction address.
REQ-015 SHALL have port upd_taken_i  input  1  actual direction.
REQ-016 SHALL have port upd_target_i  input  Width  actual target.
REQ-017 SHALL have port upd_pred_i  input  1  pred_taken_o value issued for this instruction.
REQ-018 SHALL have port upd_ghr_i  input  GhrBits  ghr_o snapshot issued for this instruction.
REQ-019 SHALL have port mispred_cnt_o  output  32  misprediction count.

Function
REQ-020 SHALL use lookup index pc_i[IdxW+1:2] and tag pc_i[IdxW+TagW+1:IdxW+2]; update uses the same fields of upd_pc_i.
REQ-021 SHALL compute lookup outputs combinationally from registered tables: hit_o = valid & tag match; pred_taken_o = hit_o & PHT counter MSB; pred_target_o = BTB target when hit_o, else pc_i+4.
REQ-022 SHALL, on a rising edge with upd_valid_i=1, increment the indexed PHT counter if upd_taken_i, else decrement it; saturate at 2^CntBits-1 and 0, with no wrap.
REQ-023 SHALL, on update with upd_taken_i=1, write valid=1, tag, and upd_target_i into the indexed BTB entry, replacing any occupant.
REQ-024 SHALL, on update with upd_taken_i=0, leave the BTB entry unchanged.
REQ-025 SHALL apply updates one cycle after the edge: a lookup in the same cycle as an update to the same index returns the pre-update contents.
REQ-026 SHALL increment mispred_cnt_o when upd_valid_i & (upd_taken_i != upd_pred_i), saturating at 32'hFFFF_FFFF.
REQ-027 SHALL ignore every update input while upd_valid_i=0.

Reset
REQ-028 SHALL, while rst_ni=0, asynchronously clear all BTB valid bits, set every PHT counter to 2^(CntBits-1)-1 (weakly not-taken), clear the GHR, and clear mispred_cnt_o.
REQ-029 SHALL drive hit_o=0, pred_taken_o=0, pred_target_o=pc_i+4, ghr_o=0, and mispred_cnt_o=0 after reset.
REQ-030 SHALL discard an update in progress when reset asserts mid-operation; no partial entry survives.

Configuration
REQ-031 SHALL, when GSHARE_EN is defined, use PHT index = (pc index) XOR zero-extended GHR; upd_ghr_i replaces the GHR when forming the update index.
REQ-032 SHALL, when GSHARE_EN is defined, shift the GHR left on every update, inserting upd_taken_i at bit 0; ghr_o shows the current GHR.
REQ-033 SHALL, when GSHARE_EN is undefined, use PHT index = pc index (bimodal), drive ghr_o to 0, ignore upd_ghr_i, and implement no GHR register.

Verification
REQ-034 SHALL cover cold lookup: after reset, pc_i=0x40 -> hit_o=0, pred_taken_o=0, pred_target_o=0x44.
REQ-035 SHALL cover allocation: update pc=0x40, taken=1, target=0x100 -> next cycle pc_i=0x40 gives hit_o=1, pred_taken_o=1 (counter 1->2), pred_target_o=0x100.
REQ-036 SHALL cover saturation: 5 taken updates to 0x40 -> counter 3; then 1 not-taken -> still predicts taken; a 2nd not-taken -> predicts not-taken.
REQ-037 SHALL cover aliasing: taken update pc=0x40, then taken update pc=0x40+4*Entries*2^... with the same index but a different tag -> lookup 0x40 gives hit_o=0.
REQ-038 SHALL cover the counter: 3 updates with upd_pred_i != upd_taken_i plus 2 matching ones -> mispred_cnt_o=3; reset asserted mid-sequence -> 0 immediately.
REQ-039 SHALL cover history (GSHARE_EN): alternating taken/not-taken updates at 0x40 with correct upd_ghr_i -> after warm-up, pred_taken_o follows the alternation with zero mispredictions.
